// File: rtl/bram_arbiter_pkg.sv
// Shared state encoding, port ids and lane-count helper for the two-port BRAM arbiter.
package bram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   function automatic int unsigned columns(input int unsigned data_w, input int unsigned col_w);
      return data_w / col_w;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant: a lone requester wins, a tie goes to the port not granted last.
module rr_arbiter_2
   import bram_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic       o_grant_valid,
   output logic       o_grant_id
);

   always_comb begin
      o_grant_valid = |i_req;
      o_grant_id    = PORT_A;
      if (i_req == 2'b11) begin
         o_grant_id = ~i_last_grant;
      end else if (i_req[1]) begin
         o_grant_id = PORT_B;
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one byte-enable single-port BRAM between ports A and B; one access in flight,
// IDLE -> ISSUE -> RESP, with a one-cycle response pulse on the granted port.
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter  int unsigned ADDRESS_BITWIDTH     = 16,
   parameter  int unsigned DATA_BITWIDTH        = 32,
   parameter  int unsigned DATA_COLUMN_BITWIDTH = 8,
   localparam int unsigned COLUMNS              = columns(DATA_BITWIDTH, DATA_COLUMN_BITWIDTH)
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst_n,

   input  logic                        a_req_valid,
   output logic                        a_req_ready,
   input  logic [ADDRESS_BITWIDTH-1:0] a_req_addr,
   input  logic [COLUMNS-1:0]          a_req_wstrb,
   input  logic [DATA_BITWIDTH-1:0]    a_req_wdata,
   output logic                        a_rsp_valid,
   output logic [DATA_BITWIDTH-1:0]    a_rsp_data,

   input  logic                        b_req_valid,
   output logic                        b_req_ready,
   input  logic [ADDRESS_BITWIDTH-1:0] b_req_addr,
   input  logic [COLUMNS-1:0]          b_req_wstrb,
   input  logic [DATA_BITWIDTH-1:0]    b_req_wdata,
   output logic                        b_rsp_valid,
   output logic [DATA_BITWIDTH-1:0]    b_rsp_data,

   output logic [COLUMNS-1:0]          bram_write_enable,
   output logic [ADDRESS_BITWIDTH-1:0] bram_address,
   output logic [DATA_BITWIDTH-1:0]    bram_data_in,
   input  logic [DATA_BITWIDTH-1:0]    bram_data_out
);

   state_t                      r_state, w_state_next;
   logic                        r_last_grant, r_grant, r_is_write;
   logic [COLUMNS-1:0]          r_bram_we;
   logic [ADDRESS_BITWIDTH-1:0] r_bram_addr;
   logic [DATA_BITWIDTH-1:0]    r_bram_din;
   logic                        r_a_rsp_valid, r_b_rsp_valid;
   logic [DATA_BITWIDTH-1:0]    r_a_rsp_data, r_b_rsp_data;

   logic                        w_grant_valid, w_grant_id, w_idle, w_accept;
   logic [ADDRESS_BITWIDTH-1:0] w_sel_addr;
   logic [COLUMNS-1:0]          w_sel_wstrb;
   logic [DATA_BITWIDTH-1:0]    w_sel_wdata;

   rr_arbiter_2 u_rr (
      .i_req         ({b_req_valid, a_req_valid}),
      .i_last_grant  (r_last_grant),
      .o_grant_valid (w_grant_valid),
      .o_grant_id    (w_grant_id)
   );

   // Ready follows the grant, so only the winner sees a handshake; nothing is taken during reset.
   assign w_idle      = sys_rst_n && (r_state == ST_IDLE);
   assign w_accept    = w_idle && w_grant_valid;
   assign a_req_ready = w_accept && (w_grant_id == PORT_A);
   assign b_req_ready = w_accept && (w_grant_id == PORT_B);

   assign w_sel_addr  = (w_grant_id == PORT_B) ? b_req_addr  : a_req_addr;
   assign w_sel_wstrb = (w_grant_id == PORT_B) ? b_req_wstrb : a_req_wstrb;
   assign w_sel_wdata = (w_grant_id == PORT_B) ? b_req_wdata : a_req_wdata;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
         ST_ISSUE: w_state_next = ST_RESP;
         ST_RESP:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_last_grant  <= PORT_B;
         r_grant       <= PORT_A;
         r_is_write    <= 1'b0;
         r_bram_we     <= '0;
         r_bram_addr   <= '0;
         r_bram_din    <= '0;
         r_a_rsp_valid <= 1'b0;
         r_b_rsp_valid <= 1'b0;
         r_a_rsp_data  <= '0;
         r_b_rsp_data  <= '0;
      end else begin
         r_a_rsp_valid <= 1'b0;
         r_b_rsp_valid <= 1'b0;
         r_a_rsp_data  <= '0;
         r_b_rsp_data  <= '0;
         if (w_accept) begin
            r_grant     <= w_grant_id;
            r_is_write  <= |w_sel_wstrb;
            r_bram_we   <= w_sel_wstrb;
            r_bram_addr <= w_sel_addr;
            r_bram_din  <= w_sel_wdata;
         end
         if (r_state == ST_ISSUE) begin
            r_bram_we <= '0;
         end
         // BRAM read data is valid in RESP; register it into the response pulse.
         if (r_state == ST_RESP) begin
            r_last_grant <= r_grant;
            if (r_grant == PORT_A) begin
               r_a_rsp_valid <= 1'b1;
               r_a_rsp_data  <= r_is_write ? '0 : bram_data_out;
            end else begin
               r_b_rsp_valid <= 1'b1;
               r_b_rsp_data  <= r_is_write ? '0 : bram_data_out;
            end
         end
      end
   end

   assign bram_write_enable = r_bram_we;
   assign bram_address      = r_bram_addr;
   assign bram_data_in      = r_bram_din;
   assign a_rsp_valid       = r_a_rsp_valid;
   assign a_rsp_data        = r_a_rsp_data;
   assign b_rsp_valid       = r_b_rsp_valid;
   assign b_rsp_data        = r_b_rsp_data;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: BRAM model, transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_bram_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
   logic        a_req_ready, b_req_ready;
   logic [15:0] a_req_addr = '0, b_req_addr = '0;
   logic [3:0]  a_req_wstrb = '0, b_req_wstrb = '0;
   logic [31:0] a_req_wdata = '0, b_req_wdata = '0;
   logic        a_rsp_valid, b_rsp_valid;
   logic [31:0] a_rsp_data, b_rsp_data;
   logic [3:0]  bram_write_enable;
   logic [15:0] bram_address;
   logic [31:0] bram_data_in;
   logic [31:0] bram_data_out = '0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   int rsp_q[$];

   bram_arbiter #(
      .ADDRESS_BITWIDTH     (16),
      .DATA_BITWIDTH        (32),
      .DATA_COLUMN_BITWIDTH (8)
   ) dut (
      .sys_clk           (sys_clk),
      .sys_rst_n         (sys_rst_n),
      .a_req_valid       (a_req_valid),
      .a_req_ready       (a_req_ready),
      .a_req_addr        (a_req_addr),
      .a_req_wstrb       (a_req_wstrb),
      .a_req_wdata       (a_req_wdata),
      .a_rsp_valid       (a_rsp_valid),
      .a_rsp_data        (a_rsp_data),
      .b_req_valid       (b_req_valid),
      .b_req_ready       (b_req_ready),
      .b_req_addr        (b_req_addr),
      .b_req_wstrb       (b_req_wstrb),
      .b_req_wdata       (b_req_wdata),
      .b_rsp_valid       (b_rsp_valid),
      .b_rsp_data        (b_rsp_data),
      .bram_write_enable (bram_write_enable),
      .bram_address      (bram_address),
      .bram_data_in      (bram_data_in),
      .bram_data_out     (bram_data_out)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Byte-enable single-port BRAM, read-first, one-cycle read latency, not reset.
   bit [31:0] bram_mem [0:65535];
   always @(posedge sys_clk) begin
      for (int i = 0; i < 4; i++) begin
         if (bram_write_enable[i]) bram_mem[bram_address][i*8 +: 8] <= bram_data_in[i*8 +: 8];
      end
      bram_data_out <= bram_mem[bram_address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: m_age counts cycles since acceptance (-1 = nothing outstanding).
   bit [31:0]   ref_mem [int];
   int          m_age = -1;
   logic        m_last = 1'b1;
   logic        m_port = 1'b0;
   logic [3:0]  m_wstrb = '0;
   logic [31:0] m_result = '0;
   logic [15:0] m_addr = '0;
   logic [31:0] m_din = '0;
   bit          m_just_reset = 1'b1;
   logic        prev_a_rsp = 1'b0, prev_b_rsp = 1'b0;

   always @(negedge sys_clk) begin
      logic        busy, win;
      logic [31:0] word;
      int          k;
      busy = (m_age == 1) || (m_age == 2);
      win  = (a_req_valid && b_req_valid) ? ~m_last : b_req_valid;
      if (chk_en) begin
         check("a_req_ready", 32'(a_req_ready), 32'(sys_rst_n && !busy && a_req_valid && !win));
         check("b_req_ready", 32'(b_req_ready), 32'(sys_rst_n && !busy && b_req_valid && win));
         check("bram_we", 32'(bram_write_enable), (m_age == 1) ? 32'(m_wstrb) : 32'h0);
         check("a_rsp_valid", 32'(a_rsp_valid), 32'(m_age == 3 && m_port == 1'b0));
         check("b_rsp_valid", 32'(b_rsp_valid), 32'(m_age == 3 && m_port == 1'b1));
         check("a_rsp_pulse_width", 32'(a_rsp_valid && prev_a_rsp), 32'h0);
         check("b_rsp_pulse_width", 32'(b_rsp_valid && prev_b_rsp), 32'h0);
         if (m_age == 3) begin
            check(m_port ? "b_rsp_data" : "a_rsp_data", m_port ? b_rsp_data : a_rsp_data, m_result);
         end
         if (m_age == 1 || m_just_reset) begin
            check("bram_address", 32'(bram_address), 32'(m_addr));
            check("bram_data_in", bram_data_in, m_din);
         end
         if (m_just_reset) begin
            check("reset_a_rsp_data", a_rsp_data, 32'h0);
            check("reset_b_rsp_data", b_rsp_data, 32'h0);
         end
      end
      prev_a_rsp = a_rsp_valid;
      prev_b_rsp = b_rsp_valid;
      if (!sys_rst_n) begin
         m_age = -1;
         m_last = 1'b1;
         m_addr = '0;
         m_din = '0;
         m_wstrb = '0;
         m_just_reset = 1'b1;
      end else begin
         m_just_reset = 1'b0;
         if (m_age == 2) m_last = m_port;
         if (busy) begin
            m_age++;
         end else if (a_req_valid || b_req_valid) begin
            m_port  = win;
            m_addr  = win ? b_req_addr : a_req_addr;
            m_wstrb = win ? b_req_wstrb : a_req_wstrb;
            m_din   = win ? b_req_wdata : a_req_wdata;
            k = int'(m_addr);
            word = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
            if (m_wstrb == 4'h0) begin
               m_result = word;
            end else begin
               for (int i = 0; i < 4; i++) if (m_wstrb[i]) word[i*8 +: 8] = m_din[i*8 +: 8];
               ref_mem[k] = word;
               m_result = 32'h0;
            end
            m_age = 1;
         end else begin
            m_age = -1;
         end
      end
   end

   always @(negedge sys_clk) begin
      if (a_rsp_valid) rsp_q.push_back(0);
      if (b_rsp_valid) rsp_q.push_back(1);
   end

   task automatic do_reset(input int n);
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b0;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      repeat (n) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
   endtask

   // One access on a port; returns response data and negedges from accept edge to the pulse.
   task automatic access(input bit port, input logic [15:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
      int  n;
      bit  hit;
      @(posedge sys_clk); #1;
      if (port) begin
         b_req_valid = 1'b1; b_req_addr = addr; b_req_wstrb = wstrb; b_req_wdata = wdata;
      end else begin
         a_req_valid = 1'b1; a_req_addr = addr; a_req_wstrb = wstrb; a_req_wdata = wdata;
      end
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
         hit = port ? (b_req_valid && b_req_ready) : (a_req_valid && a_req_ready);
      end while (!hit && n < 20);
      check("accepted", 32'(hit), 32'h1);
      @(posedge sys_clk); #1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
         hit = port ? b_rsp_valid : a_rsp_valid;
      end while (!hit && n < 10);
      check("rsp_seen", 32'(hit), 32'h1);
      rdata = port ? b_rsp_data : a_rsp_data;
      lat = n;
   endtask

   initial begin
      logic [31:0] rd;
      int          lat, n, accepts;
      int          acc_cyc[$];
      int          first_port;

      #6 chk_en = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;

      // Write then read back on A.
      access(1'b0, 16'd4, 4'hf, 32'habcd_ef12, rd, lat);
      check("t1_write_rsp_data", rd, 32'h0);
      access(1'b0, 16'd4, 4'h0, 32'h0, rd, lat);
      check("t1_read_data", rd, 32'habcd_ef12);
      check("t1_read_latency", 32'(lat), 32'd3);

      // Partial write of lane 0 only.
      access(1'b0, 16'd4, 4'b0001, 32'h1111_1177, rd, lat);
      check("t2_write_rsp_data", rd, 32'h0);
      access(1'b0, 16'd4, 4'h0, 32'h0, rd, lat);
      check("t2_read_data", rd, 32'habcd_ef77);

      // Tie held for four accesses after reset: A,B,A,B.
      do_reset(2);
      @(posedge sys_clk); #1;
      rsp_q.delete();
      a_req_valid = 1'b1; a_req_addr = 16'd4; a_req_wstrb = 4'h0;
      b_req_valid = 1'b1; b_req_addr = 16'd8; b_req_wstrb = 4'h0;
      accepts = 0; n = 0;
      while (accepts < 4 && n < 40) begin
         @(negedge sys_clk);
         n++;
         if ((a_req_valid && a_req_ready) || (b_req_valid && b_req_ready)) accepts++;
      end
      check("t3_accepts", 32'(accepts), 32'd4);
      @(posedge sys_clk); #1;
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      repeat (5) @(negedge sys_clk);
      check("t3_rsp_count", 32'(rsp_q.size()), 32'd4);
      if (rsp_q.size() == 4) begin
         check("t3_order0", 32'(rsp_q[0]), 32'd0);
         check("t3_order1", 32'(rsp_q[1]), 32'd1);
         check("t3_order2", 32'(rsp_q[2]), 32'd0);
         check("t3_order3", 32'(rsp_q[3]), 32'd1);
      end

      // B alone, held: accepted every third cycle, A silent.
      @(posedge sys_clk); #1;
      rsp_q.delete();
      acc_cyc.delete();
      b_req_valid = 1'b1; b_req_addr = 16'd4; b_req_wstrb = 4'h0;
      n = 0;
      while (acc_cyc.size() < 4 && n < 40) begin
         @(negedge sys_clk);
         n++;
         if (b_req_valid && b_req_ready) acc_cyc.push_back(cyc);
      end
      @(posedge sys_clk); #1;
      b_req_valid = 1'b0;
      repeat (5) @(negedge sys_clk);
      check("t4_accepts", 32'(acc_cyc.size()), 32'd4);
      for (int i = 1; i < acc_cyc.size(); i++) begin
         check("t4_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
      end
      check("t4_a_rsp_count", 32'(rsp_q.find_index() with (item == 0).size()), 32'd0);

      // Reset during ISSUE of a read: no response, then A wins the next tie.
      @(posedge sys_clk); #1;
      a_req_valid = 1'b1; a_req_addr = 16'd4; a_req_wstrb = 4'h0;
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!(a_req_valid && a_req_ready) && n < 20);
      @(posedge sys_clk); #1;
      rsp_q.delete();
      a_req_valid = 1'b0;
      sys_rst_n = 1'b0;
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
      check("t5_no_rsp", 32'(rsp_q.size()), 32'd0);
      @(posedge sys_clk); #1;
      a_req_valid = 1'b1; b_req_valid = 1'b1;
      first_port = -1; n = 0;
      while (first_port < 0 && n < 20) begin
         @(negedge sys_clk);
         n++;
         if (a_req_valid && a_req_ready) first_port = 0;
         else if (b_req_valid && b_req_ready) first_port = 1;
      end
      check("t5_first_grant", 32'(first_port), 32'd0);
      @(posedge sys_clk); #1;
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      repeat (4) @(posedge sys_clk);

      // Random traffic with occasional resets.
      for (int c = 0; c < 1500; c++) begin
         @(posedge sys_clk); #1;
         sys_rst_n   = ($urandom_range(0, 79) != 0);
         a_req_valid = ($urandom_range(0, 2) != 0);
         a_req_addr  = 16'($urandom_range(0, 15));
         a_req_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
         a_req_wdata = $urandom;
         b_req_valid = ($urandom_range(0, 2) != 0);
         b_req_addr  = 16'($urandom_range(0, 15));
         b_req_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
         b_req_wdata = $urandom;
      end
      @(posedge sys_clk); #1;
      sys_rst_n = 1'b1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      repeat (6) @(posedge sys_clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
